// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter (and the future receiver).
//
// Contents:
//   parity_e      - frame parity mode (PAR_NONE / PAR_EVEN / PAR_ODD)
//   uart_state_e  - transmit/receive frame FSM states
//   calc_parity   - parity bit for a data word under a given mode
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StPar   = 3'd3,
        StStop  = 3'd4
    } uart_state_e;

    // Widest supported data word; narrower words are zero-extended by the caller,
    // which leaves the XOR reduction unchanged.
    localparam int unsigned MAX_DATA_BITS = 9;

    // Even parity is the XOR of the data bits, odd parity its inverse.
    // PAR_NONE returns 0 (the bit is never transmitted in that mode).
    function automatic logic calc_parity(logic [MAX_DATA_BITS-1:0] word, parity_e mode);
        logic p;
        p = ^word;
        unique case (mode)
            PAR_EVEN: calc_parity = p;
            PAR_ODD:  calc_parity = ~p;
            default:  calc_parity = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Write-side handshake of the UART transmitter.
//
// Signals:
//   tx_data   - word to send, LSB transmitted first
//   tx_valid  - tx_data valid
//   tx_ready  - transmitter can accept a word (FIFO not full)
// A word transfers on every rising edge where tx_valid and tx_ready are both high.
//
// Modports:
//   master - producer of words (drives tx_data / tx_valid)
//   slave  - the transmitter (drives tx_ready)
interface uart_tx_param_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding words waiting to be serialised.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (clears pointers and level)
//   push, wdata - write request and data; ignored while full
//   pop         - read request; ignored while empty
//   rdata       - word at the head of the FIFO (valid while !empty)
//   full, empty - occupancy flags
//   level       - number of words held, 0..DEPTH
//
// Reads come straight from storage, so a word written into an empty FIFO is
// only visible at rdata from the cycle after the write.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign level   = level_q;

    // Storage needs no reset: pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a small transmit FIFO.
//
// Parameters:
//   OVERSAMPLE - clock cycles per bit (4..256)
//   DATA_BITS  - data bits per frame (5..9)
//   PARITY     - PAR_NONE / PAR_EVEN / PAR_ODD
//   STOP_BITS  - 1 or 2
//   FIFO_DEPTH - transmit FIFO entries, power of two (2..64)
//
// Ports:
//   clk        - single clock, all logic on the rising edge
//   rst_n      - asynchronous active-low reset; aborts any frame and empties the FIFO
//   bus        - write handshake (tx_data / tx_valid / tx_ready), slave side
//   fifo_level - words currently queued in the FIFO
//   busy       - a frame is in progress or words are queued
//   tx         - registered serial output, idles high
//
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1),
// each bit held exactly OVERSAMPLE cycles. Consecutive queued words go out
// back-to-back with no idle gap.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter parity_e     PARITY     = PAR_EVEN,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    uart_tx_param_if.slave                  bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            busy,
    output logic                            tx
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (OVERSAMPLE < 4 || OVERSAMPLE > 256) begin : gen_bad_oversample
        $error("uart_tx_param: OVERSAMPLE must be in 4..256");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : gen_bad_parity
        $error("uart_tx_param: PARITY must be PAR_NONE, PAR_EVEN or PAR_ODD");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : gen_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_fifo_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two in 2..64");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam bit                HAS_PAR   = (PARITY != PAR_NONE);

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LVL_W-1:0]     fifo_level_w;
    logic                 pop;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.tx_valid),
        .wdata (bus.tx_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_w)
    );

    // Ready depends on fullness only; the FIFO itself drops pushes while full.
    assign bus.tx_ready = !fifo_full;
    assign fifo_level   = fifo_level_w;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    uart_state_e          state_q;
    logic [TICK_W-1:0]    tick_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 tx_q;

    logic                 last_tick;
    logic                 frame_done;
    logic                 next_par;

    assign last_tick  = (tick_q == TICK_LAST);
    assign frame_done = (state_q == StStop) && last_tick && (bit_q == STOP_LAST);

    // Pop either from idle or on the final tick of the last stop bit, which
    // chains the next frame with no idle cycle in between.
    assign pop = !fifo_empty && ((state_q == StIdle) || frame_done);

    // Parity is taken from the popped word, so later changes on tx_data are irrelevant.
    assign next_par = calc_parity(MAX_DATA_BITS'(fifo_rdata), PARITY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        state_q <= StStart;
                        tick_q  <= '0;
                        bit_q   <= '0;
                        shift_q <= fifo_rdata;
                        par_q   <= next_par;
                        tx_q    <= 1'b0;
                    end
                end

                StStart: begin
                    if (last_tick) begin
                        tick_q  <= '0;
                        state_q <= StData;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end

                StData: begin
                    if (last_tick) begin
                        tick_q <= '0;
                        if (bit_q == DATA_LAST) begin
                            bit_q <= '0;
                            if (HAS_PAR) begin
                                state_q <= StPar;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= StStop;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + BIT_W'(1);
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end

                StPar: begin
                    if (last_tick) begin
                        tick_q  <= '0;
                        bit_q   <= '0;
                        state_q <= StStop;
                        tx_q    <= 1'b1;
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end

                StStop: begin
                    if (last_tick) begin
                        tick_q <= '0;
                        if (bit_q == STOP_LAST) begin
                            bit_q <= '0;
                            if (pop) begin
                                state_q <= StStart;
                                shift_q <= fifo_rdata;
                                par_q   <= next_par;
                                tx_q    <= 1'b0;
                            end else begin
                                state_q <= StIdle;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_q <= tick_q + TICK_W'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                    tick_q  <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != StIdle) || (fifo_level_w != '0);

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: three instances cover the default frame,
// odd parity, and a 7-bit / no parity / 2 stop configuration.
module tb_uart_tx_param;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // d0: defaults (16x, 8 bits, even parity, 1 stop, depth 4)
    uart_tx_param_if #(.DATA_BITS(8)) if0 ();
    logic [2:0] lvl0;
    logic       busy0, tx0;
    uart_tx_param u_d0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if0.slave),
        .fifo_level (lvl0),
        .busy       (busy0),
        .tx         (tx0)
    );

    // d1: odd parity
    uart_tx_param_if #(.DATA_BITS(8)) if1 ();
    logic [2:0] lvl1;
    logic       busy1, tx1;
    uart_tx_param #(.PARITY(PAR_ODD)) u_d1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if1.slave),
        .fifo_level (lvl1),
        .busy       (busy1),
        .tx         (tx1)
    );

    // d2: 7 data bits, no parity, 2 stop bits
    uart_tx_param_if #(.DATA_BITS(7)) if2 ();
    logic [2:0] lvl2;
    logic       busy2, tx2;
    uart_tx_param #(.DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2)) u_d2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if2.slave),
        .fifo_level (lvl2),
        .busy       (busy2),
        .tx         (tx2)
    );

    // Frames are written LSB-first: bit 0 is the start bit.
    task automatic test_reset();
        if0.tx_valid = 1'b0; if0.tx_data = '0;
        if1.tx_valid = 1'b0; if1.tx_data = '0;
        if2.tx_valid = 1'b0; if2.tx_data = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx0 !== 1'b1) $display("FAIL reset_tx0 got=%b exp=1", tx0); else passed++;
        checks++; if (if0.tx_ready !== 1'b1) $display("FAIL reset_ready0 got=%b exp=1", if0.tx_ready); else passed++;
        checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy0 got=%b exp=0", busy0); else passed++;
        checks++; if (lvl0 !== 3'd0) $display("FAIL reset_level0 got=%0d exp=0", lvl0); else passed++;
        checks++; if (tx1 !== 1'b1) $display("FAIL reset_tx1 got=%b exp=1", tx1); else passed++;
        checks++; if (tx2 !== 1'b1) $display("FAIL reset_tx2 got=%b exp=1", tx2); else passed++;
    endtask

    // First push on the first edge after release, then the 0x55 frame.
    task automatic test_default_frame();
        logic [10:0] f;
        int errs, first_bad;
        logic par_seen, busy_last;
        f = 11'b1_0_0101_0101_0;
        rst_n = 1'b1;
        if0.tx_data = 8'h55;
        if0.tx_valid = 1'b1;
        @(posedge clk); #1;
        if0.tx_valid = 1'b0;
        if0.tx_data = 8'hFF;  // must not affect the queued word
        checks++; if (lvl0 !== 3'd1) $display("FAIL first_push_level got=%0d exp=1", lvl0); else passed++;
        checks++; if (tx0 !== 1'b1) $display("FAIL no_bypass_tx got=%b exp=1", tx0); else passed++;
        errs = 0; first_bad = -1; par_seen = 1'bx; busy_last = 1'bx;
        for (int c = 0; c < 176; c++) begin
            @(posedge clk); #1;
            if (tx0 !== f[c/16]) begin
                errs++;
                if (first_bad < 0) first_bad = c;
            end
            if (c == 9*16 + 8) par_seen = tx0;
            if (c == 175) busy_last = busy0;
        end
        checks++; if (errs != 0) $display("FAIL frame_55 bad_cycles=%0d first_bad=%0d exp=0", errs, first_bad); else passed++;
        checks++; if (par_seen !== 1'b0) $display("FAIL parity_55 got=%b exp=0", par_seen); else passed++;
        checks++; if (busy_last !== 1'b1) $display("FAIL busy_cycle175 got=%b exp=1", busy_last); else passed++;
        @(posedge clk); #1;
        checks++; if (busy0 !== 1'b0) $display("FAIL busy_after_frame got=%b exp=0", busy0); else passed++;
        checks++; if (tx0 !== 1'b1) $display("FAIL idle_after_frame got=%b exp=1", tx0); else passed++;
    endtask

    task automatic test_odd_parity();
        logic [10:0] f;
        logic [7:0] w;
        logic exp_par, par_seen;
        int errs;
        for (int k = 0; k < 2; k++) begin
            w       = (k == 0) ? 8'h00 : 8'h01;
            exp_par = (k == 0) ? 1'b1 : 1'b0;
            f       = (k == 0) ? 11'b1_1_0000_0000_0 : 11'b1_0_0000_0001_0;
            if1.tx_data = w;
            if1.tx_valid = 1'b1;
            @(posedge clk); #1;
            if1.tx_valid = 1'b0;
            errs = 0; par_seen = 1'bx;
            for (int c = 0; c < 176; c++) begin
                @(posedge clk); #1;
                if (tx1 !== f[c/16]) errs++;
                if (c == 9*16 + 3) par_seen = tx1;
            end
            checks++; if (par_seen !== exp_par) $display("FAIL odd_parity_%0d got=%b exp=%b", k, par_seen, exp_par); else passed++;
            checks++; if (errs != 0) $display("FAIL odd_frame_%0d bad_cycles=%0d exp=0", k, errs); else passed++;
            @(posedge clk); #1;
            checks++; if (busy1 !== 1'b0) $display("FAIL odd_idle_%0d busy=%b exp=0", k, busy1); else passed++;
        end
    endtask

    task automatic test_seven_bit_two_stop();
        logic [9:0] f;
        int errs;
        logic busy_last, stop2_seen;
        f = 10'b11_111_1111_0;
        if2.tx_data = 7'h7F;
        if2.tx_valid = 1'b1;
        @(posedge clk); #1;
        if2.tx_valid = 1'b0;
        errs = 0; busy_last = 1'bx; stop2_seen = 1'bx;
        for (int c = 0; c < 160; c++) begin
            @(posedge clk); #1;
            if (tx2 !== f[c/16]) errs++;
            if (c == 150) stop2_seen = tx2;
            if (c == 159) busy_last = busy2;
        end
        checks++; if (errs != 0) $display("FAIL frame_7n2 bad_cycles=%0d exp=0", errs); else passed++;
        checks++; if (stop2_seen !== 1'b1) $display("FAIL stop2_7n2 got=%b exp=1", stop2_seen); else passed++;
        checks++; if (busy_last !== 1'b1) $display("FAIL busy_cycle159 got=%b exp=1", busy_last); else passed++;
        @(posedge clk); #1;
        checks++; if (busy2 !== 1'b0) $display("FAIL busy_after_7n2 got=%b exp=0", busy2); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [10:0] fr [3];
        int errs, first_bad;
        logic [2:0] lvl_seen;
        fr[0] = 11'b1_1_1010_0001_0;  // 0xA1, parity 1
        fr[1] = 11'b1_0_1011_0010_0;  // 0xB2, parity 0
        fr[2] = 11'b1_0_1100_0011_0;  // 0xC3, parity 0
        if0.tx_data = 8'hA1;
        if0.tx_valid = 1'b1;
        @(posedge clk); #1;
        if0.tx_data = 8'hB2;
        errs = 0; first_bad = -1; lvl_seen = 'x;
        for (int c = 0; c < 528; c++) begin
            @(posedge clk); #1;
            if (c == 0) if0.tx_data = 8'hC3;
            if (c == 1) begin
                if0.tx_valid = 1'b0;
                lvl_seen = lvl0;
            end
            if (tx0 !== fr[c/176][(c%176)/16]) begin
                errs++;
                if (first_bad < 0) first_bad = c;
            end
        end
        checks++; if (lvl_seen !== 3'd2) $display("FAIL b2b_level got=%0d exp=2", lvl_seen); else passed++;
        checks++; if (errs != 0) $display("FAIL b2b_frames bad_cycles=%0d first_bad=%0d exp=0", errs, first_bad); else passed++;
        @(posedge clk); #1;
        checks++; if (busy0 !== 1'b0) $display("FAIL b2b_idle busy=%b exp=0", busy0); else passed++;
    endtask

    task automatic test_overflow();
        logic [10:0] fr [5];
        int accepted, errs, first_bad;
        fr[0] = 11'b1_1_0001_0000_0;  // 0x10
        fr[1] = 11'b1_0_0001_0001_0;  // 0x11
        fr[2] = 11'b1_0_0001_0010_0;  // 0x12
        fr[3] = 11'b1_1_0001_0011_0;  // 0x13
        fr[4] = 11'b1_0_0001_0100_0;  // 0x14
        accepted = 0; errs = 0; first_bad = -1;
        if0.tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if0.tx_data = 8'(8'h10 + i);
            if (if0.tx_ready === 1'b1) accepted++;
            @(posedge clk); #1;
            if (i >= 1 && tx0 !== 1'b0) errs++;  // start bit of first frame
        end
        if0.tx_valid = 1'b0;
        checks++; if (accepted != 5) $display("FAIL ovf_accepted got=%0d exp=5", accepted); else passed++;
        checks++; if (lvl0 !== 3'd4) $display("FAIL ovf_level got=%0d exp=4", lvl0); else passed++;
        checks++; if (if0.tx_ready !== 1'b0) $display("FAIL ovf_ready got=%b exp=0", if0.tx_ready); else passed++;
        for (int c = 5; c < 880; c++) begin
            @(posedge clk); #1;
            if (tx0 !== fr[c/176][(c%176)/16]) begin
                errs++;
                if (first_bad < 0) first_bad = c;
            end
        end
        checks++; if (errs != 0) $display("FAIL ovf_frames bad_cycles=%0d first_bad=%0d exp=0", errs, first_bad); else passed++;
        @(posedge clk); #1;
        checks++; if (busy0 !== 1'b0) $display("FAIL ovf_idle busy=%b exp=0", busy0); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        if0.tx_data = 8'h55;
        if0.tx_valid = 1'b1;
        @(posedge clk); #1;
        if0.tx_data = 8'hA1;
        @(posedge clk); #1;              // frame cycle 0
        if0.tx_data = 8'hB2;
        @(posedge clk); #1;              // frame cycle 1
        if0.tx_valid = 1'b0;
        repeat (78) @(posedge clk);
        #1;                              // frame cycle 79: data bit 3 of 0x55 = 0
        checks++; if (tx0 !== 1'b0) $display("FAIL pre_reset_tx got=%b exp=0", tx0); else passed++;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (tx0 !== 1'b1) $display("FAIL mid_reset_tx got=%b exp=1", tx0); else passed++;
        checks++; if (lvl0 !== 3'd0) $display("FAIL mid_reset_level got=%0d exp=0", lvl0); else passed++;
        checks++; if (busy0 !== 1'b0) $display("FAIL mid_reset_busy got=%b exp=0", busy0); else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        checks++; if (bad != 0) $display("FAIL post_reset_quiet bad_cycles=%0d exp=0", bad); else passed++;
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_odd_parity();
        test_seven_bit_two_stop();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter OVERSAMPLE, default 16: clock cycles per bit; legal range 4..256.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default PAR_EVEN: PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, 2..64.
REQ-006 clk  input  1  single clock, 16x baud at default OVERSAMPLE; all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 tx_data  input  DATA_BITS  byte/word to send, LSB transmitted first.
REQ-009 tx_valid  input  1  tx_data valid; accepted on any cycle where tx_valid and tx_ready are both high.
REQ-010 tx_ready  output  1  high when the FIFO is not full.
REQ-011 fifo_level  output  $clog2(FIFO_DEPTH+1)  entries currently held in the FIFO.
REQ-012 busy  output  1  high when the FSM is not IDLE or fifo_level is non-zero.
REQ-013 tx  output  1  serial line, registered, idle high.

Function
REQ-014 Frame SHALL be: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1); each bit held exactly OVERSAMPLE cycles.
REQ-015 Frame length SHALL be OVERSAMPLE*(1+DATA_BITS+(PARITY!=PAR_NONE)+STOP_BITS) cycles; defaults give 176.
REQ-016 Even parity bit SHALL be XOR of data bits; odd parity its inverse; computed on the popped word, not on tx_data.
REQ-017 FSM states SHALL be IDLE, START, DATA, PAR, STOP; PAR skipped when PARITY=PAR_NONE.
REQ-018 IDLE->START when FIFO non-empty: pop in cycle N, tx low from cycle N+1.
REQ-019 START->DATA, DATA->PAR/STOP and PAR->STOP each occur when tick counter reaches OVERSAMPLE-1; a bit counter selects data bit index and stop bit index.
REQ-020 At the last tick of the final stop bit: if FIFO non-empty, pop and go to START with no idle gap; else go to IDLE with tx high.
REQ-021 A word written into an empty FIFO SHALL be popped no earlier than the following cycle; no bypass path.
REQ-022 tx_ready SHALL depend only on full; a push while full is dropped and not counted.
REQ-023 Simultaneous push and pop SHALL leave fifo_level unchanged and both operations take effect.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_level is 0..FIFO_DEPTH inclusive.
REQ-025 Changing tx_data after acceptance SHALL not affect any queued or in-flight frame.
REQ-026 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-027 While rst_n low: tx=1, tx_ready=1, busy=0, fifo_level=0, FSM=IDLE, all counters 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame and discard FIFO contents immediately (asynchronously); no partial frame resumes after release.
REQ-029 First push accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 Package uart_pkg SHALL hold the parity enum (PAR_NONE/PAR_EVEN/PAR_ODD) and the FSM state enum, shared with the future receiver.
REQ-031 FIFO SHALL be a sub-module uart_tx_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level); FSM, tick counter, bit counter and shift register live in uart_tx_param.

Verification
REQ-032 Defaults, push 0x55 -> tx: 0,1,0,1,0,1,0,1,0, parity 0, stop 1, each bit 16 cycles, frame 176 cycles, busy low 1 cycle after frame end.
REQ-033 PARITY=PAR_ODD, push 0x00 -> parity bit 1; push 0x01 -> parity bit 0.
REQ-034 DATA_BITS=7, PARITY=PAR_NONE, STOP_BITS=2, push 0x7F -> frame 160 cycles, two 16-cycle stop bits.
REQ-035 Defaults, push 0xA1,0xB2,0xC3 back-to-back -> 528 contiguous frame cycles, no idle high cycle between frames, correct order.
REQ-036 Defaults, hold tx_valid high 6 cycles with tx idle -> 5 accepted (1 in flight + 4 queued), tx_ready low, 6th dropped, fifo_level=4.
REQ-037 Pull rst_n low at cycle 80 of a frame -> tx=1 same cycle, fifo_level=0; after release no further frame bits appear.
